// File: rtl/mips_pkg.sv
// Shared defaults for the MIPS register file and its write-back scoreboard.
package mips_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/mips_scoreboard.sv
// Per-register pending bits set at issue and cleared at write-back, with a
// running pending count and a one-cycle error pulse on a redundant reservation.
module mips_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic                   rsv_en_i,
  input  logic [ADDR_W-1:0]      rsv_addr_i,
  output logic [2**ADDR_W-1:0]   pending_o,
  output logic [ADDR_W:0]        pending_count_o,
  output logic                   reserve_err_o
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             err_q, err_d;

  logic wr_live, rsv_live, same_reg, eff_set, eff_clr;

  assign wr_live  = wr_en_i  && (wr_addr_i  != ADDR_W'(REG_ZERO));
  assign rsv_live = rsv_en_i && (rsv_addr_i != ADDR_W'(REG_ZERO));
  assign same_reg = wr_live && rsv_live && (wr_addr_i == rsv_addr_i);

  // A write-back to the reserved register frees it first, so re-reserving it is legal.
  assign eff_clr = wr_live && pend_q[wr_addr_i];
  assign eff_set = rsv_live && (!pend_q[rsv_addr_i] || same_reg);

  always_comb begin
    pend_d = pend_q;
    if (wr_live)  pend_d[wr_addr_i]  = 1'b0;
    if (rsv_live) pend_d[rsv_addr_i] = 1'b1;
    count_d = count_q + (ADDR_W+1)'(eff_set) - (ADDR_W+1)'(eff_clr);
    err_d   = rsv_live && pend_q[rsv_addr_i] && !same_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign pending_o       = pend_q;
  assign pending_count_o = count_q;
  assign reserve_err_o   = err_q;

endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS general-purpose register file with hardwired $zero, optional write-to-read
// bypass and an integrated RAW-hazard scoreboard.
module mips_regfile_sb
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   read_reg,
  output logic [NUM_RD*DATA_W-1:0]   read_data,
  output logic [NUM_RD-1:0]          read_busy,
  input  logic [ADDR_W-1:0]          write_reg,
  input  logic [DATA_W-1:0]          write_data,
  input  logic                       signal_reg_write,
  input  logic [ADDR_W-1:0]          reserve_reg,
  input  logic                       signal_reserve,
  output logic [ADDR_W:0]            pending_count,
  output logic                       reserve_err
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pending;
  logic              wr_live;

  assign wr_live = signal_reg_write && (write_reg != ADDR_W'(REG_ZERO));

  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[write_reg] = write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    assign ra  = read_reg[i*ADDR_W +: ADDR_W];
    assign hit = (BYPASS != 0) && wr_live && (write_reg == ra);
    assign read_data[i*DATA_W +: DATA_W] =
      (ra == ADDR_W'(REG_ZERO)) ? '0 : (hit ? write_data : regs_q[ra]);
    // A register being written back this cycle is no longer a hazard once forwarded.
    assign read_busy[i] = pending[ra] & ~hit;
  end

  mips_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en_i         (signal_reg_write),
    .wr_addr_i       (write_reg),
    .rsv_en_i        (signal_reserve),
    .rsv_addr_i      (reserve_reg),
    .pending_o       (pending),
    .pending_count_o (pending_count),
    .reserve_err_o   (reserve_err)
  );

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Bench for mips_regfile_sb: bypassing and non-bypassing instances driven in lockstep
// and compared against an array-based architectural model.
module tb_mips_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int N  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] read_reg;
  logic [NR*DW-1:0] rd_b, rd_n;
  logic [NR-1:0]    busy_b, busy_n;
  logic [AW-1:0]    write_reg, reserve_reg;
  logic [DW-1:0]    write_data;
  logic             we, rsv;
  logic [AW:0]      cnt_b, cnt_n;
  logic             err_b, err_n;

  mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .read_reg(read_reg), .read_data(rd_b), .read_busy(busy_b),
    .write_reg(write_reg), .write_data(write_data), .signal_reg_write(we),
    .reserve_reg(reserve_reg), .signal_reserve(rsv),
    .pending_count(cnt_b), .reserve_err(err_b));

  mips_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .read_reg(read_reg), .read_data(rd_n), .read_busy(busy_n),
    .write_reg(write_reg), .write_data(write_data), .signal_reg_write(we),
    .reserve_reg(reserve_reg), .signal_reserve(rsv),
    .pending_count(cnt_n), .reserve_err(err_n));

  logic [DW-1:0] m_regs [N];
  bit            m_pend [N];
  bit            m_err;
  int            n_pass = 0;
  int            n_total = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < N; r++) c += int'(m_pend[r]);
    return c;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < N; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic set_idle();
    we = 1'b0; rsv = 1'b0; write_reg = '0; reserve_reg = '0; write_data = '0;
  endtask

  task automatic set_rd(int a0, int a1);
    read_reg[0 +: AW]  = AW'(a0);
    read_reg[AW +: AW] = AW'(a1);
  endtask

  task automatic check_comb();
    for (int i = 0; i < NR; i++) begin
      int  a;
      bit  hit;
      a   = int'(read_reg[i*AW +: AW]);
      hit = we && (int'(write_reg) == a) && (a != 0);
      chk("rd_byp",   rd_b[i*DW +: DW], (a == 0) ? '0 : (hit ? write_data : m_regs[a]));
      chk("rd_nob",   rd_n[i*DW +: DW], (a == 0) ? '0 : m_regs[a]);
      chk("busy_byp", busy_b[i], m_pend[a] && !hit);
      chk("busy_nob", busy_n[i], m_pend[a]);
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    bit e;
    #1 check_comb();
    @(posedge clk);
    e = rsv && (reserve_reg != 0) && m_pend[reserve_reg] &&
        !(we && (write_reg == reserve_reg));
    if (we && write_reg != 0) begin
      m_regs[write_reg] = write_data;
      m_pend[write_reg] = 1'b0;
    end
    if (rsv && reserve_reg != 0) m_pend[reserve_reg] = 1'b1;
    m_err = e;
    @(negedge clk);
    chk("cnt_byp", cnt_b, m_count());
    chk("cnt_nob", cnt_n, m_count());
    chk("err_byp", err_b, m_err);
    chk("err_nob", err_n, m_err);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    set_idle();
    set_rd(0, 0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < N; a++) begin
      set_rd(a, N - 1 - a);
      cycle();
    end

    // Write r5 with same-cycle read; bypass instance forwards, other sees old value.
    set_rd(5, 0);
    we = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
    #1;
    chk("r5_bypass", rd_b[DW-1:0], 32'hDEADBEEF);
    chk("r5_nob_same", rd_n[DW-1:0], 32'h0);
    cycle();
    set_idle();
    #1 chk("r5_nob_next", rd_n[DW-1:0], 32'hDEADBEEF);
    cycle();

    set_rd(0, 0);
    we = 1'b1; write_reg = 5'd0; write_data = 32'h1234;
    #1 chk("r0_write_read", rd_b[DW-1:0], 32'h0);
    cycle();
    set_idle();

    set_rd(0, 7);
    rsv = 1'b1; reserve_reg = 5'd7;
    cycle();
    chk("r7_cnt1", cnt_b, 1);
    set_idle();
    #1 chk("r7_busy", busy_b[1], 1'b1);
    cycle();
    we = 1'b1; write_reg = 5'd7; write_data = 32'h55;
    #1;
    chk("r7_busy_wb_byp", busy_b[1], 1'b0);
    chk("r7_busy_wb_nob", busy_n[1], 1'b1);
    cycle();
    chk("r7_cnt0", cnt_b, 0);
    set_idle();

    rsv = 1'b1; reserve_reg = 5'd7;
    cycle();
    cycle();
    chk("r7_dup_err", err_b, 1'b1);
    chk("r7_dup_cnt", cnt_b, 1);
    set_idle();
    cycle();
    chk("r7_err_pulse", err_b, 1'b0);

    set_rd(9, 9);
    rsv = 1'b1; reserve_reg = 5'd9;
    cycle();
    we = 1'b1; write_reg = 5'd9; write_data = 32'hABCD;
    cycle();
    chk("r9_cnt", cnt_b, 2);
    chk("r9_err", err_b, 1'b0);
    set_idle();
    #1;
    chk("r9_busy", busy_b[0], 1'b1);
    chk("r9_data", rd_n[DW-1:0], 32'hABCD);
    cycle();

    for (int k = 0; k < 400; k++) begin
      we          = 1'($urandom_range(0, 1));
      write_reg   = AW'($urandom_range(0, N - 1));
      write_data  = $urandom;
      rsv         = 1'($urandom_range(0, 1));
      reserve_reg = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom_range(0, N - 1));
      set_rd(($urandom_range(0, 2) == 0) ? int'(write_reg) : int'($urandom_range(0, N - 1)),
             int'($urandom_range(0, N - 1)));
      cycle();
    end

    set_idle();
    for (int r = 1; r < N; r++) begin
      we = 1'b1; write_reg = AW'(r); write_data = $urandom | 32'h1;
      cycle();
    end
    set_idle();
    for (int r = 1; r < N; r++) begin
      rsv = 1'b1; reserve_reg = AW'(r);
      cycle();
    end
    chk("all_rsv_cnt", cnt_b, 31);
    set_idle();
    set_rd(5, 9);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst_cnt", cnt_b, 0);
    chk("arst_busy", busy_b, 2'b00);
    chk("arst_data", rd_b, 64'h0);
    chk("arst_data_nob", rd_n, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mips_regfile_sb.md
# mips_regfile_sb

Parametrised MIPS general-purpose register file with an integrated write-back scoreboard, the pipelined successor to `mips_registers`. It provides a configurable number of combinational read ports, one clocked write port with optional same-cycle write-to-read bypass, and a hardwired `$zero` register. Per-register pending bits are set at issue and cleared at write-back, so the decode stage can detect RAW hazards. It sits between decode/issue and the write-back stage of the pipelined datapath.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, register address width; `NREGS = 2**ADDR_W`
- `NUM_RD`, 2, number of read ports (≥1)
- `BYPASS`, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `read_reg`  in  `NUM_RD*ADDR_W`  packed read addresses; port i at `[i*ADDR_W +: ADDR_W]`
- `read_data`  out  `NUM_RD*DATA_W`  packed read data, same packing
- `read_busy`  out  `NUM_RD`  1 = register on port i awaits write-back
- `write_reg`  in  `ADDR_W`  write address
- `write_data`  in  `DATA_W`  write data
- `signal_reg_write`  in  1  write enable
- `reserve_reg`  in  `ADDR_W`  register to mark pending
- `signal_reserve`  in  1  reservation enable
- `pending_count`  out  `ADDR_W+1`  number of pending registers
- `reserve_err`  out  1  registered one-cycle pulse: reservation of an already-pending register

## Operation
- Register 0: reads return 0, `read_busy` 0; writes and reservations to it ignored (no count change, no error).
- Write: on rising `clk` with `signal_reg_write`=1 and `write_reg`≠0, `regs[write_reg] <= write_data`; if pending, bit cleared.
- Write to a non-pending register: data stored, pending unchanged (legal).
- Reserve: on rising `clk` with `signal_reserve`=1 and `reserve_reg`≠0, pending bit set.
- Reserve of a register already pending and not cleared in the same cycle: pending unchanged, count unchanged, `reserve_err`=1 next cycle.
- Reserve and write to the same register in one cycle: write clears, reserve sets; result pending=1, data stored, count unchanged, no error.
- Read, per port: if `BYPASS`=1, write enabled, `write_reg`==`read_reg[i]`≠0 → `read_data[i]`=`write_data`, else stored value.
- `read_busy[i]` = `pending[read_reg[i]]` & ~(`BYPASS` & write hit on that address). Same-cycle reservation does not affect current-cycle `read_busy`.
- `pending_count` next = current + (effective set) − (effective clear); never wraps (max `NREGS`−1).

## Timing
- Reset (`rst_n`=0, asynchronous, any time incl. mid-operation): all registers 0, all pending 0, `pending_count`=0, `reserve_err`=0; `read_data` all 0 and `read_busy` all 0 immediately.
- Write/reserve latency: 1 cycle to storage; bypass path 0 cycles.
- `read_data`, `read_busy`: combinational from inputs and state.
- `pending_count`, `reserve_err`: registered, updated on the same edge as state.
- No handshake; all enables are single-cycle qualifiers sampled at each rising edge.

## Structure
- Shared package `mips_pkg`: default `DATA_W`, `ADDR_W`, `REG_ZERO` constant (0).
- Sub-module `mips_scoreboard`: pending bit vector, `pending_count` counter, `reserve_err` register; inputs write/reserve address+enable, outputs pending vector.
- Register array, zero-register masking and bypass muxes in top level.

## Test plan
- Reset then read all 32 registers on both ports → `read_data`=0, `read_busy`=0, `pending_count`=0.
- Write 0xDEADBEEF to r5, read r5 on port 0 same cycle (BYPASS=1) → 0xDEADBEEF; with BYPASS=0 → 0 that cycle, 0xDEADBEEF next; write 0x1234 to r0 → reads 0.
- Reserve r7 → next cycle `read_busy[1]`=1 on r7, count=1; write r7=0x55 → busy 0 in write cycle (BYPASS=1), count=0 next.
- Reserve r7 twice without write-back → `reserve_err` pulses 1 for one cycle, count stays 1.
- Same cycle write r9 (pending) and reserve r9 → r9=data, still pending, count unchanged, no error.
- Reserve r1..r31 → count=31; assert `rst_n`=0 mid-sequence between edges → count, busy, data 0 immediately.
